// File: rtl/simd_sign_split_pkg.sv
// simd_sign_split_pkg: shared op encoding, sew one-hot constants and width defaults
package simd_sign_split_pkg;
   localparam int MIN_W = 8;
   localparam int MAX_W = 64;
   typedef enum logic [1:0] {
      OP_MUL = 2'b00,
      OP_DIV = 2'b01,
      OP_REM = 2'b10,
      OP_RSV = 2'b11
   } op_e;
   localparam logic [3:0] SEW_64 = 4'b0001;
   localparam logic [3:0] SEW_32 = 4'b0010;
   localparam logic [3:0] SEW_16 = 4'b0100;
   localparam logic [3:0] SEW_8  = 4'b1000;
endpackage

// File: rtl/simd_sign_split_abs.sv
// simd_abs: per-element magnitude and replicated sign mask, recursive halving at sew boundaries
module simd_abs #(
   parameter int W   = 64,
   parameter int MIN = 8,
   parameter int SW  = 4
) (
   input  logic [W-1:0]     x,
   input  logic [SW-1:0]    sel,
   input  logic             sgn,
   output logic [W-1:0]     mag,
   output logic [W/MIN-1:0] neg
);
   logic s;
   assign s = sgn & x[W-1];
   generate
      if (W > MIN) begin : g_split
         logic [W-1:0]     sub_mag;
         logic [W/MIN-1:0] sub_neg;
         simd_abs #(.W(W/2), .MIN(MIN), .SW(SW-1)) u_lo (
            .x(x[W/2-1:0]), .sel(sel[SW-1:1]), .sgn(sgn),
            .mag(sub_mag[W/2-1:0]), .neg(sub_neg[W/MIN/2-1:0])
         );
         simd_abs #(.W(W/2), .MIN(MIN), .SW(SW-1)) u_hi (
            .x(x[W-1:W/2]), .sel(sel[SW-1:1]), .sgn(sgn),
            .mag(sub_mag[W-1:W/2]), .neg(sub_neg[W/MIN-1:W/MIN/2])
         );
         // lowest sew bit is checked first, so the widest selected element wins
         assign mag = sel[0] ? (s ? -x : x) : sub_mag;
         assign neg = sel[0] ? {(W/MIN){s}} : sub_neg;
      end else begin : g_leaf
         logic unused_sel;
         assign unused_sel = ^sel;
         assign mag = s ? -x : x;
         assign neg = {(W/MIN){s}};
      end
   endgenerate
endmodule

// File: rtl/simd_sign_split.sv
// simd_sign_split: 2-stage valid/ready front end turning signed SIMD operands into magnitudes plus a negate mask
module simd_sign_split
   import simd_sign_split_pkg::*;
#(
   parameter int MIN_WIDTH = MIN_W,
   parameter int MAX_WIDTH = MAX_W,
   parameter int SEW_WIDTH = $clog2(MAX_WIDTH/MIN_WIDTH)+1,
   parameter int TAG_WIDTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           valid_i,
   output logic                           ready_o,
   input  logic [MAX_WIDTH-1:0]           opA,
   input  logic [MAX_WIDTH-1:0]           opB,
   input  logic [SEW_WIDTH-1:0]           sew,
   input  logic                           is_signed,
   input  logic [1:0]                     op,
   input  logic [TAG_WIDTH-1:0]           tag_i,
   output logic                           valid_o,
   input  logic                           ready_i,
   output logic [MAX_WIDTH-1:0]           magA,
   output logic [MAX_WIDTH-1:0]           magB,
   output logic [MAX_WIDTH/MIN_WIDTH-1:0] change,
   output logic [SEW_WIDTH-1:0]           sew_o,
   output logic [TAG_WIDTH-1:0]           tag_o
);
   localparam int NC = MAX_WIDTH/MIN_WIDTH;
   logic                 s1_valid, s2_valid, s2_adv, s1_sgn;
   logic [MAX_WIDTH-1:0] s1_a, s1_b, abs_a, abs_b;
   logic [SEW_WIDTH-1:0] s1_sew;
   logic [TAG_WIDTH-1:0] s1_tag;
   logic [NC-1:0]        neg_a, neg_b;
   op_e                  s1_op;
   assign s2_adv  = !s2_valid || ready_i;
   assign ready_o = !s1_valid || s2_adv;
   assign valid_o = s2_valid;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_sew   <= '0;
         s1_sgn   <= 1'b0;
         s1_op    <= OP_MUL;
         s1_tag   <= '0;
      end else if (ready_o) begin
         s1_valid <= valid_i;
         if (valid_i) begin
            s1_a   <= opA;
            s1_b   <= opB;
            s1_sew <= sew;
            s1_sgn <= is_signed;
            s1_op  <= op_e'(op);
            s1_tag <= tag_i;
         end
      end
   end
   simd_abs #(.W(MAX_WIDTH), .MIN(MIN_WIDTH), .SW(SEW_WIDTH)) u_abs_a (
      .x(s1_a), .sel(s1_sew), .sgn(s1_sgn), .mag(abs_a), .neg(neg_a)
   );
   simd_abs #(.W(MAX_WIDTH), .MIN(MIN_WIDTH), .SW(SEW_WIDTH)) u_abs_b (
      .x(s1_b), .sel(s1_sew), .sgn(s1_sgn), .mag(abs_b), .neg(neg_b)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         magA     <= '0;
         magB     <= '0;
         change   <= '0;
         sew_o    <= '0;
         tag_o    <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            magA   <= abs_a;
            magB   <= abs_b;
            change <= (s1_op == OP_REM) ? neg_a : neg_a ^ neg_b;
            sew_o  <= s1_sew;
            tag_o  <= s1_tag;
         end
      end
   end
endmodule

// File: tb/tb_simd_sign_split.sv
// tb_simd_sign_split: randomized and directed checks against an arithmetic per-element reference model
module tb_simd_sign_split;
   logic        clk, rst, valid_i, ready_o, is_signed, valid_o, ready_i;
   logic [63:0] opA, opB, magA, magB;
   logic [3:0]  sew, tag_i, sew_o, tag_o;
   logic [1:0]  op;
   logic [7:0]  change;
   int          n_tests = 0, n_fail = 0, mode = 0;
   typedef struct packed {
      logic [63:0] ma, mb;
      logic [7:0]  ch;
      logic [3:0]  sw, tg;
   } exp_t;
   exp_t q[$];

   simd_sign_split dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
      .opA(opA), .opB(opB), .sew(sew), .is_signed(is_signed), .op(op),
      .tag_i(tag_i), .valid_o(valid_o), .ready_i(ready_i),
      .magA(magA), .magB(magB), .change(change), .sew_o(sew_o), .tag_o(tag_o)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic [3:0] s,
                                  input logic sg, input logic [1:0] o, input logic [3:0] t);
      exp_t        r;
      int          w;
      logic [63:0] mask, ea, eb;
      logic        sa, sb, c;
      r = '0;
      r.sw = s;
      r.tg = t;
      w = 8;
      for (int k = 3; k >= 0; k--) if (s[k]) w = 64 >> k;
      mask = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
      for (int e = 0; e < 64 / w; e++) begin
         ea = (a >> (e * w)) & mask;
         eb = (b >> (e * w)) & mask;
         sa = sg && ea[w-1];
         sb = sg && eb[w-1];
         r.ma |= (sa ? (-ea & mask) : ea) << (e * w);
         r.mb |= (sb ? (-eb & mask) : eb) << (e * w);
         c = (o == 2'b10) ? sa : sa ^ sb;
         for (int j = 0; j < w / 8; j++) r.ch[e * w / 8 + j] = c;
      end
      return r;
   endfunction

   // scoreboard: every valid output cycle is compared with the oldest outstanding request
   always @(negedge clk) begin
      if (!rst) begin
         if (valid_o) begin
            if (q.size() == 0) chk("spurious_output", 1, 0);
            else begin
               chk("magA", magA, q[0].ma);
               chk("magB", magB, q[0].mb);
               chk("change", {56'd0, change}, {56'd0, q[0].ch});
               chk("sew_o", {60'd0, sew_o}, {60'd0, q[0].sw});
               chk("tag_o", {60'd0, tag_o}, {60'd0, q[0].tg});
               if (ready_i) void'(q.pop_front());
            end
         end
         if (valid_i && ready_o) q.push_back(model(opA, opB, sew, is_signed, op, tag_i));
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0: ready_i = 1'b1;
            1: ready_i = ~ready_i;
            2: ready_i = 1'($urandom);
            default: ready_i = 1'b0;
         endcase
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [3:0] s,
                       input logic sg, input logic [1:0] o, input logic [3:0] t);
      logic acc;
      acc = 1'b0;
      opA = a; opB = b; sew = s; is_signed = sg; op = o; tag_i = t; valid_i = 1'b1;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         acc = ready_o;
         @(posedge clk);
         #1;
      end
      if (!acc) chk("accept_timeout", 0, 1);
      valid_i = 1'b0;
   endtask

   task automatic drain();
      int i;
      i = 0;
      while ((q.size() != 0 || valid_o) && i < 300) begin
         @(posedge clk);
         #1;
         i++;
      end
      chk("drain_empty", q.size(), 0);
   endtask

   task automatic latency();
      chk("lat_early", valid_o, 0);
      @(posedge clk);
      #1;
      chk("lat_2cyc", valid_o, 1);
   endtask

   initial begin
      rst = 1; valid_i = 0; ready_i = 1; opA = 0; opB = 0; sew = 0; is_signed = 0; op = 0; tag_i = 0;
      #12;
      chk("rst_valid_o", valid_o, 0);
      chk("rst_magA", magA, 0);
      chk("rst_magB", magB, 0);
      chk("rst_change", {56'd0, change}, 0);
      chk("rst_sew_o", {60'd0, sew_o}, 0);
      chk("rst_tag_o", {60'd0, tag_o}, 0);
      @(negedge clk);
      rst = 0;
      #1;
      chk("ready_after_rst", ready_o, 1);
      @(posedge clk);
      #1;
      send(64'h80FF0001_7F8001FE, 64'h01010101_01010101, 4'b1000, 1, 2'b00, 4'd1);
      latency();
      chk("s8_magA", magA, 64'h80010001_7F800102);
      chk("s8_change", {56'd0, change}, 64'hC5);
      drain();
      send(64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 4'b0001, 1, 2'b01, 4'd2);
      latency();
      chk("s64_magA", magA, 64'd5);
      chk("s64_magB", magB, 64'd3);
      chk("s64_change", {56'd0, change}, 64'hFF);
      drain();
      send(64'hFFFF_FFFF_FFFF_FFFF, {$urandom, $urandom}, 4'b0100, 0, 2'b00, 4'd3);
      latency();
      chk("uns_magA", magA, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("uns_change", {56'd0, change}, 0);
      drain();
      send(64'h80000000_00000007, 64'h80000001_FFFFFFF0, 4'b0010, 1, 2'b10, 4'd4);
      latency();
      chk("rem_change", {56'd0, change}, 64'hF0);
      chk("rem_magA", magA, 64'h80000000_00000007);
      drain();
      mode = 1;
      for (int t = 0; t < 8; t++)
         send({$urandom, $urandom}, {$urandom, $urandom}, 4'(1 << $urandom_range(0, 3)), 1,
              2'($urandom), 4'(t));
      drain();
      mode = 2;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         send({$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom), 1'($urandom),
              2'($urandom), 4'($urandom));
      end
      drain();
      mode = 3;
      @(posedge clk);
      #1;
      send({$urandom, $urandom}, {$urandom, $urandom}, 4'b1000, 1, 2'b00, 4'd9);
      send({$urandom, $urandom}, {$urandom, $urandom}, 4'b0010, 1, 2'b01, 4'd10);
      chk("full_valid_o", valid_o, 1);
      chk("full_ready_o", ready_o, 0);
      #1;
      rst = 1;
      q.delete();
      #1;
      chk("midrst_valid_o", valid_o, 0);
      chk("midrst_magA", magA, 0);
      chk("midrst_tag_o", {60'd0, tag_o}, 0);
      mode = 0;
      @(negedge clk);
      rst = 0;
      #1;
      chk("post_rst_ready", ready_o, 1);
      @(posedge clk);
      #1;
      send(64'h00000000_0000FF80, 64'h0, 4'b0100, 1, 2'b00, 4'd11);
      latency();
      chk("post_rst_tag", {60'd0, tag_o}, 64'd11);
      chk("post_rst_magA", magA, 64'h00000000_00000080);
      drain();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/simd_sign_split.md
SIMD_SIGN_SPLIT -- requirements
Module: simd_sign_split

Interface
REQ-001 Parameters SHALL be:
- MIN_WIDTH, default 8, narrowest element width.
- MAX_WIDTH, default 64, datapath width.
- SEW_WIDTH, default $clog2(MAX_WIDTH/MIN_WIDTH)+1, width of the sew field.
- TAG_WIDTH, default 4, width of the opaque tag.
REQ-002 Ports (clock and reset first):
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- valid_i  in  1  input request valid.
- ready_o  out  1  input request accepted when high with valid_i.
- opA  in  MAX_WIDTH  packed signed elements, operand A.
- opB  in  MAX_WIDTH  packed signed elements, operand B.
- sew  in  SEW_WIDTH  one-hot; bit k set means element width MAX_WIDTH>>k.
- is_signed  in  1  operands are signed; 0 means bypass (no negation).
- op  in  2  00=MUL, 01=DIV, 10=REM, 11=reserved (treated as MUL).
- tag_i  in  TAG_WIDTH  opaque, travels with the request.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- magA  out  MAX_WIDTH  per-element magnitude of opA.
- magB  out  MAX_WIDTH  per-element magnitude of opB.
- change  out  MAX_WIDTH/MIN_WIDTH  result-negate mask, one bit per MIN_WIDTH chunk.
- sew_o  out  SEW_WIDTH  sew carried with the request.
- tag_o  out  TAG_WIDTH  tag carried with the request.

Function
REQ-003 The block SHALL be the sign-stripping front end of the lane: it converts signed operands to magnitudes and emits the change mask consumed by the sign-restore stage.
REQ-004 The block SHALL be a 2-stage valid/ready pipeline; an accepted request appears at the outputs exactly 2 cycles later when ready_i stays high.
- S1 registers operands and computes sign bits.
- S2 registers magnitudes and the change mask.
REQ-005 A stage SHALL advance when its output register is empty or is being consumed in the same cycle.
- ready_o = !S1_valid || S1 advancing.
- Full throughput is 1 request per cycle.
REQ-006 When valid_o=1 and ready_i=0, all outputs SHALL hold stable until the handshake completes.
REQ-007 An element's sign SHALL be its MSB when is_signed=1, and 0 otherwise.
REQ-008 Magnitude SHALL be two's-complement negation within the element when the sign is 1, and the element unchanged otherwise.
- Carries SHALL NOT cross element boundaries.
- The most-negative value (e.g. 0x80 at SEW=8) SHALL yield 0x80, read as unsigned 128.
REQ-009 Each element's change bit SHALL be signA^signB for MUL/DIV and signA for REM.
- The bit SHALL be replicated on every MIN_WIDTH chunk of that element.
REQ-010 If sew is not one-hot, the lowest-index set bit (widest element) SHALL win; sew=0 SHALL select MIN_WIDTH elements.
REQ-011 Simultaneous S2 drain and S1 fill, together with a new acceptance in the same cycle, SHALL lose and duplicate no request.
REQ-012 sew_o and tag_o SHALL be aligned with the data of the same request.

Reset
REQ-013 Asserting rst SHALL immediately clear both stage valid bits, including mid-operation, and discard in-flight requests.
REQ-014 During reset, valid_o, magA, magB, change, sew_o and tag_o SHALL be 0, and ready_o SHALL be 1 after reset deasserts.
REQ-015 Data registers SHALL be cleared on reset.

Structure
REQ-016 A shared vector package SHALL hold:
- the op encoding enum;
- the sew one-hot constants;
- the MIN_WIDTH/MAX_WIDTH defaults.
REQ-017 One sub-module, simd_abs, SHALL compute per-element magnitude and sign combinationally.
- It SHALL be a recursive split at SEW boundaries.
- It SHALL be instantiated once per operand in S2.

Verification
REQ-018 Scenario: sew=4'b1000, signed, MUL, opA=0x80FF0001_7F8001FE, opB=0x01010101_01010101.
- Required: magA=0x80010001_7F8001 02.
- Required: change=8'b1100_0101.
REQ-019 Scenario: sew=4'b0001, signed, DIV, opA=-5, opB=3.
- Required: magA=5, magB=3, change=8'hFF, after 2 cycles.
REQ-020 Scenario: sew=4'b0100, is_signed=0, opA=0xFFFF_FFFF_FFFF_FFFF.
- Required: magA equals opA and change=0.
REQ-021 Scenario: back-to-back 8 requests, tags 0..7, with ready_i toggling every cycle.
- Required: tags exit in order 0..7, none lost or duplicated, outputs stable while stalled.
REQ-022 Scenario: rst asserted with both stages valid.
- Required: valid_o=0 in the same cycle.
- Required: the first post-reset request emerges 2 cycles after acceptance.
REQ-023 Scenario: REM, sew=4'b0010, opA=0x80000000_00000007, opB all negative.
- Required: change=8'b1111_0000, magA upper element=0x80000000.
